cpu_run_monitor: RTL and testbench

Synthesizable run monitor downstream of `mips_cpu_harvard`. It consumes the CPU's `active`, `instr_address` and `register_v0` outputs and tracks a program run from reset vector to halt. It counts cycles and distinct fetches, captures the final `register_v0`, and raises a registered pass/fail verdict against an expected value. Testbenches and the FPGA wrapper both use it in place of per-test ad-hoc assertions.

---
 rtl/cpu_run_monitor.sv | 154 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: tracks one CPU program run from the first reset-vector fetch to halt or timeout.
// Counts enabled cycles and distinct fetches, captures $v0 at halt, and flags pass/fail against expected_v0.
// Ports: clk/reset/clk_enable; CPU taps active, instr_address, register_v0; reference expected_v0;
//        verdict done/pass/fail/timeout/misaligned; statistics cycles, fetches, result_v0.
module cpu_run_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  input  logic [31:0] register_v0,
  input  logic [31:0] expected_v0,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        misaligned,
  output logic [31:0] cycles,
  output logic [31:0] fetches,
  output logic [31:0] result_v0
);

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TOUT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] prev_addr;
  logic [31:0] prev_addr_nxt;
  logic        done_nxt;
  logic        pass_nxt;
  logic        timeout_nxt;
  logic        misaligned_nxt;
  logic [31:0] cycles_nxt;
  logic [31:0] fetches_nxt;
  logic [31:0] result_v0_nxt;

  logic start_cond;
  logic halt_cond;
  logic timeout_hit;
  logic mis_seen;

  assign start_cond  = active && (instr_address == RESET_VECTOR);
  assign halt_cond   = !active || (instr_address == 32'h0);
  // Compared against the count already registered, so the run gets exactly
  // TIMEOUT_CYCLES enabled cycles in RUN before the timeout edge.
  assign timeout_hit = (cycles == TIMEOUT_LIM);
  // Sticky misalignment including the fetch on this edge, so a bad fetch on
  // the halt edge itself still spoils the verdict.
  assign mis_seen    = misaligned || (instr_address[1:0] != 2'b00);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_nxt;
    end
  end

  // Next-state logic; halt has priority over timeout on the same edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_cond) state_nxt = RUN;
      RUN: begin
        if (halt_cond)        state_nxt = HALT;
        else if (timeout_hit) state_nxt = TOUT;
      end
      default: state_nxt = state;  // HALT and TOUT leave only via reset
    endcase
  end

  // Next values for the registered flags and counters
  always_comb begin
    done_nxt       = done;
    pass_nxt       = pass;
    timeout_nxt    = timeout;
    misaligned_nxt = misaligned;
    cycles_nxt     = cycles;
    fetches_nxt    = fetches;
    result_v0_nxt  = result_v0;
    prev_addr_nxt  = prev_addr;
    case (state)
      IDLE: begin
        if (start_cond) begin
          cycles_nxt    = 32'd1;
          fetches_nxt   = 32'd1;
          prev_addr_nxt = instr_address;
        end
      end
      RUN: begin
        if (!halt_cond && timeout_hit) begin
          // Counters freeze at the limit on the timeout edge
          done_nxt      = 1'b1;
          timeout_nxt   = 1'b1;
          pass_nxt      = 1'b0;
          result_v0_nxt = register_v0;
        end else begin
          cycles_nxt     = sat_inc(cycles);
          if (instr_address != prev_addr) fetches_nxt = sat_inc(fetches);
          prev_addr_nxt  = instr_address;
          misaligned_nxt = mis_seen;
          if (halt_cond) begin
            done_nxt      = 1'b1;
            pass_nxt      = (register_v0 == expected_v0) && !mis_seen;
            result_v0_nxt = register_v0;
          end
        end
      end
      default: ;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      misaligned <= 1'b0;
      cycles     <= 32'd0;
      fetches    <= 32'd0;
      result_v0  <= 32'd0;
      prev_addr  <= 32'd0;
    end else if (clk_enable) begin
      done       <= done_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
      misaligned <= misaligned_nxt;
      cycles     <= cycles_nxt;
      fetches    <= fetches_nxt;
      result_v0  <= result_v0_nxt;
      prev_addr  <= prev_addr_nxt;
    end
  end

  assign fail = done && !pass;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed scenarios plus randomized runs against a run-level reference model.
module tb_cpu_run_monitor;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active = 1'b0;
  logic [31:0] instr_address = 32'h0;
  logic [31:0] register_v0 = 32'h0;
  logic [31:0] expected_v0 = 32'h0;
  logic        done, pass, fail, timeout, misaligned;
  logic [31:0] cycles, fetches, result_v0;

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_monitor #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .register_v0(register_v0), .expected_v0(expected_v0),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .misaligned(misaligned),
    .cycles(cycles), .fetches(fetches), .result_v0(result_v0)
  );

  always #5 clk = ~clk;

  // Reference model: a run is "waiting", "running" or "over" (ended cleanly or by timeout)
  bit          m_running, m_over, m_tout, m_pass, m_mis;
  logic [31:0] m_cycles, m_fetches, m_res, m_last;

  task automatic model_edge();
    bit stop;
    if (reset) begin
      m_running = 0; m_over = 0; m_tout = 0; m_pass = 0; m_mis = 0;
      m_cycles = 0; m_fetches = 0; m_res = 0; m_last = 0;
    end else if (clk_enable) begin
      stop = !active || instr_address == 32'h0;
      if (!m_running && !m_over) begin
        if (active && instr_address == RV) begin
          m_running = 1; m_cycles = 1; m_fetches = 1; m_last = instr_address;
        end
      end else if (m_running) begin
        if (!stop && m_cycles == 32'(TO)) begin
          m_running = 0; m_over = 1; m_tout = 1; m_pass = 0; m_res = register_v0;
        end else begin
          if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
          if (instr_address != m_last && m_fetches != 32'hFFFF_FFFF) m_fetches = m_fetches + 1;
          m_last = instr_address;
          if (instr_address % 4 != 0) m_mis = 1;
          if (stop) begin
            m_running = 0; m_over = 1; m_res = register_v0;
            m_pass = (register_v0 == expected_v0) && !m_mis;
          end
        end
      end
    end
  endtask

  // One clock: model sees the same inputs the DUT samples; outputs read 1ns after the edge
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; clk_enable = 1; active = 0; instr_address = 0;
    tick();
    reset = 0;
  endtask

  task automatic start_run(input logic [31:0] v0, input logic [31:0] ev);
    do_reset();
    active = 1; instr_address = RV; register_v0 = v0; expected_v0 = ev;
    tick();
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    n_checks++;
    if ({done, pass, fail, timeout, misaligned} !== 5'b0)
      begin n_errors++; $display("FAIL reset_flags: got %b expected 00000", {done, pass, fail, timeout, misaligned}); end
    n_checks++;
    if ({cycles, fetches, result_v0} !== 96'b0)
      begin n_errors++; $display("FAIL reset_counters: got %h expected 0", {cycles, fetches, result_v0}); end
    reset = 0;
  endtask

  task automatic test_clean_halt();
    start_run(32'd1, 32'd1);
    for (int i = 0; i < 6; i++) begin instr_address = instr_address + 4; tick(); end
    n_checks++;
    if ({done, cycles, fetches} !== {1'b0, 32'd7, 32'd7})
      begin n_errors++; $display("FAIL clean_midrun: got done=%b cyc=%0d fet=%0d expected 0/7/7", done, cycles, fetches); end
    instr_address = 0;
    tick();
    n_checks++;
    if ({done, pass, fail, cycles, fetches, result_v0} !== {3'b110, 32'd8, 32'd8, 32'd1})
      begin n_errors++; $display("FAIL clean_halt: got d=%b p=%b f=%b cyc=%0d fet=%0d v0=%0d expected 1/1/0/8/8/1",
                                 done, pass, fail, cycles, fetches, result_v0); end
  endtask

  task automatic test_wrong_result();
    start_run(32'd5, 32'd1);
    for (int i = 0; i < 6; i++) begin instr_address = instr_address + 4; tick(); end
    instr_address = 0;
    tick();
    n_checks++;
    if ({done, pass, fail, result_v0} !== {3'b101, 32'd5})
      begin n_errors++; $display("FAIL wrong_result: got d=%b p=%b f=%b v0=%0d expected 1/0/1/5", done, pass, fail, result_v0); end
  endtask

  task automatic test_timeout();
    start_run(32'd3, 32'd3);
    instr_address = RV + 4;
    for (int i = 0; i < TO - 1; i++) tick();
    n_checks++;
    if ({done, timeout, cycles} !== {2'b00, 32'd16})
      begin n_errors++; $display("FAIL timeout_edge_before: got d=%b t=%b cyc=%0d expected 0/0/16", done, timeout, cycles); end
    tick();
    n_checks++;
    if ({done, timeout, pass, cycles, fetches} !== {3'b110, 32'd16, 32'd2})
      begin n_errors++; $display("FAIL timeout: got d=%b t=%b p=%b cyc=%0d fet=%0d expected 1/1/0/16/2",
                                 done, timeout, pass, cycles, fetches); end
    instr_address = 0; tick(); tick();
    n_checks++;
    if ({done, timeout, pass, cycles, fetches} !== {3'b110, 32'd16, 32'd2})
      begin n_errors++; $display("FAIL timeout_frozen: got d=%b t=%b p=%b cyc=%0d fet=%0d expected 1/1/0/16/2",
                                 done, timeout, pass, cycles, fetches); end
  endtask

  task automatic test_timeout_halt_tie();
    start_run(32'd9, 32'd9);
    instr_address = RV + 4;
    for (int i = 0; i < TO - 1; i++) tick();
    instr_address = 0;
    tick();
    n_checks++;
    if ({done, timeout, pass, fail} !== 4'b1010)
      begin n_errors++; $display("FAIL tie_halt_wins: got d=%b t=%b p=%b f=%b expected 1/0/1/0", done, timeout, pass, fail); end
  endtask

  task automatic test_enable_gating();
    start_run(32'd2, 32'd2);
    instr_address = RV + 4; tick();
    instr_address = RV + 8; tick();
    clk_enable = 0;
    for (int i = 0; i < 5; i++) begin
      instr_address = (i == 2) ? 32'h0 : RV + 32'(12 + 4 * i);
      active = (i != 3);
      tick();
    end
    n_checks++;
    if ({done, timeout, cycles, fetches} !== {2'b00, 32'd3, 32'd3})
      begin n_errors++; $display("FAIL gate_hold: got d=%b t=%b cyc=%0d fet=%0d expected 0/0/3/3", done, timeout, cycles, fetches); end
    clk_enable = 1; active = 1; instr_address = RV + 12;
    tick();
    n_checks++;
    if ({done, cycles, fetches} !== {1'b0, 32'd4, 32'd4})
      begin n_errors++; $display("FAIL gate_resume: got d=%b cyc=%0d fet=%0d expected 0/4/4", done, cycles, fetches); end
  endtask

  task automatic test_misaligned();
    start_run(32'd7, 32'd7);
    instr_address = RV + 6; tick();
    n_checks++;
    if ({misaligned, done} !== 2'b10)
      begin n_errors++; $display("FAIL misaligned_flag: got m=%b d=%b expected 1/0", misaligned, done); end
    instr_address = 0; tick();
    n_checks++;
    if ({misaligned, done, pass, fail, result_v0} !== {4'b1101, 32'd7})
      begin n_errors++; $display("FAIL misaligned_verdict: got m=%b d=%b p=%b f=%b v0=%0d expected 1/1/0/1/7",
                                 misaligned, done, pass, fail, result_v0); end
  endtask

  task automatic test_reset_mid_run();
    start_run(32'd4, 32'd4);
    instr_address = RV + 4; tick();
    instr_address = RV + 6; tick();
    n_checks++;
    if (cycles !== 32'd3)
      begin n_errors++; $display("FAIL midrun_cycles: got %0d expected 3", cycles); end
    reset = 1; tick(); reset = 0;
    n_checks++;
    if ({done, pass, fail, timeout, misaligned, cycles, fetches, result_v0} !== 101'b0)
      begin n_errors++; $display("FAIL midrun_reset: got %h expected 0",
                                 {done, pass, fail, timeout, misaligned, cycles, fetches, result_v0}); end
    instr_address = RV + 8; tick(); tick();
    n_checks++;
    if ({done, cycles, fetches} !== 65'b0)
      begin n_errors++; $display("FAIL no_restart: got d=%b cyc=%0d fet=%0d expected 0/0/0", done, cycles, fetches); end
    instr_address = RV; tick();
    n_checks++;
    if ({done, cycles, fetches} !== {1'b0, 32'd1, 32'd1})
      begin n_errors++; $display("FAIL restart: got d=%b cyc=%0d fet=%0d expected 0/1/1", done, cycles, fetches); end
  endtask

  task automatic test_random();
    logic [100:0] got, exp;
    for (int run = 0; run < 60; run++) begin
      do_reset();
      for (int c = 0; c < 28; c++) begin
        clk_enable = ($urandom_range(0, 7) != 0);
        active     = ($urandom_range(0, 11) != 0);
        case ($urandom_range(0, 9))
          0, 1:    instr_address = RV;
          2, 3, 4: instr_address = instr_address + 4;
          5, 6:    instr_address = instr_address;
          7:       instr_address = instr_address + 2;
          8:       instr_address = (c > 3) ? 32'h0 : RV;
          default: instr_address = $urandom;
        endcase
        register_v0 = 32'($urandom_range(0, 3));
        expected_v0 = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) reset = 1;
        tick();
        reset = 0;
        got = {done, pass, fail, timeout, misaligned, cycles, fetches, result_v0};
        exp = {m_over, m_pass, m_over && !m_pass, m_tout, m_mis, m_cycles, m_fetches, m_res};
        n_checks++;
        if (got !== exp)
          begin n_errors++; $display("FAIL random run=%0d cyc=%0d: got %h expected %h", run, c, got, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_halt();
    test_wrong_result();
    test_timeout();
    test_timeout_halt_tie();
    test_enable_gating();
    test_misaligned();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
